// File: rtl/glb_ld_dma_addr_gen_pkg.sv
// Shared types and constants for the GLB load-DMA address generator.
//   loop_ctrl_t      : per-level {range, stride}, stride counted in words
//   dma_ld_header_t  : load descriptor as presented at the head of the header queue
//   rdrq_packet_t    : {rd_en, rd_addr} read request toward the bank/SRAM read path
//   ld_dma_state_t   : controller state
package glb_ld_dma_addr_gen_pkg;

  localparam int GLB_ADDR_WIDTH          = 22;
  localparam int BANK_DATA_WIDTH         = 64;
  localparam int LOOP_LEVEL              = 4;
  localparam int MAX_NUM_WORDS_WIDTH     = 16;
  localparam int MAX_STRIDE_WIDTH        = 10;
  localparam int LD_DMA_START_DROP_WIDTH = 8;

  // Byte address advances by BANK_DATA_WIDTH/8 per word, applied as a shift.
  localparam int ADDR_SHIFT = $clog2(BANK_DATA_WIDTH / 8);

  typedef struct packed {
    logic [MAX_NUM_WORDS_WIDTH-1:0] range;
    logic [MAX_STRIDE_WIDTH-1:0]    stride;
  } loop_ctrl_t;

  typedef struct packed {
    logic                           valid;
    logic [GLB_ADDR_WIDTH-1:0]      start_addr;
    logic [MAX_NUM_WORDS_WIDTH-1:0] num_active_words;
    logic [MAX_NUM_WORDS_WIDTH-1:0] num_inactive_words;
    loop_ctrl_t [LOOP_LEVEL-1:0]    loop_ctrl;
  } dma_ld_header_t;

  typedef struct packed {
    logic                      rd_en;
    logic [GLB_ADDR_WIDTH-1:0] rd_addr;
  } rdrq_packet_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    INACTIVE = 2'd2,
    DONE     = 2'd3
  } ld_dma_state_t;

endpackage

// File: rtl/glb_ld_dma_addr_gen_loop_iter.sv
// Nested loop iterator: LOOP_LEVEL range counters plus stride accumulators.
// Level 0 is innermost. acc[i] holds sum_{j>=i} itr_j*stride_j, so acc[0]
// is the word offset of the current iteration without any multiplier.
// The "current" iteration is the reset point (all zero, new loop_ctrl) in a
// load cycle, otherwise the registered state; a step advances past it.
//   clk, reset    : clock, synchronous active-high reset
//   load_i        : start a new iteration space from loop_ctrl_i
//   step_i        : the current iteration is consumed this cycle
//   loop_ctrl_i   : per-level range/stride, sampled on load_i
//   offset_o      : word offset of the current iteration
//   last_o        : current iteration is the final one
module glb_loop_iter
  import glb_ld_dma_addr_gen_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_i,
  input  logic                      step_i,
  input  loop_ctrl_t [LOOP_LEVEL-1:0] loop_ctrl_i,
  output logic [GLB_ADDR_WIDTH-1:0] offset_o,
  output logic                      last_o
);

  loop_ctrl_t [LOOP_LEVEL-1:0]                     ctrl_q;
  logic [LOOP_LEVEL-1:0][MAX_NUM_WORDS_WIDTH-1:0]  itr_q, itr_d;
  logic [LOOP_LEVEL-1:0][GLB_ADDR_WIDTH-1:0]       acc_q, acc_d;

  loop_ctrl_t [LOOP_LEVEL-1:0]                     cur_ctrl_s;
  logic [LOOP_LEVEL-1:0][MAX_NUM_WORDS_WIDTH-1:0]  cur_itr_s;
  logic [LOOP_LEVEL-1:0][GLB_ADDR_WIDTH-1:0]       cur_acc_s;
  logic [LOOP_LEVEL-1:0]                           end_s;

  // Select the current iteration and flag levels sitting on their final count.
  always_comb begin
    if (load_i) begin
      cur_ctrl_s = loop_ctrl_i;
      cur_itr_s  = '0;
      cur_acc_s  = '0;
    end else begin
      cur_ctrl_s = ctrl_q;
      cur_itr_s  = itr_q;
      cur_acc_s  = acc_q;
    end
    // A range of 0 behaves as 1: the level never advances past itr 0.
    for (int i = 0; i < LOOP_LEVEL; i++) begin
      end_s[i] = (({1'b0, cur_itr_s[i]} + {{MAX_NUM_WORDS_WIDTH{1'b0}}, 1'b1})
                  >= {1'b0, cur_ctrl_s[i].range});
    end
  end

  // Ripple the step through the levels and rebuild the accumulators.
  always_comb begin
    logic                      carry_v;
    logic [GLB_ADDR_WIDTH-1:0] acc_carry_v;
    logic [LOOP_LEVEL-1:0]     inc_v;
    logic [LOOP_LEVEL-1:0]     wrap_v;
    carry_v     = step_i;
    acc_carry_v = '0;
    inc_v       = '0;
    wrap_v      = '0;
    itr_d       = cur_itr_s;
    acc_d       = cur_acc_s;
    for (int i = 0; i < LOOP_LEVEL; i++) begin
      if (carry_v) begin
        if (end_s[i]) begin
          itr_d[i]  = '0;
          wrap_v[i] = 1'b1;
        end else begin
          itr_d[i] = cur_itr_s[i] + MAX_NUM_WORDS_WIDTH'(1'b1);
          inc_v[i] = 1'b1;
          carry_v  = 1'b0;
        end
      end else begin
        itr_d[i] = cur_itr_s[i];
      end
    end
    // The incremented level adds its stride; every wrapped level below it
    // restarts from that level's new accumulator value.
    for (int i = LOOP_LEVEL - 1; i >= 0; i--) begin
      if (inc_v[i]) begin
        acc_d[i]    = cur_acc_s[i] + GLB_ADDR_WIDTH'(cur_ctrl_s[i].stride);
        acc_carry_v = acc_d[i];
      end else if (wrap_v[i]) begin
        acc_d[i] = acc_carry_v;
      end else begin
        acc_d[i] = cur_acc_s[i];
      end
    end
  end

  // Iterator state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      itr_q  <= '0;
      acc_q  <= '0;
    end else if (load_i || step_i) begin
      ctrl_q <= cur_ctrl_s;
      itr_q  <= itr_d;
      acc_q  <= acc_d;
    end
  end

  assign offset_o = cur_acc_s[0];
  assign last_o   = &end_s;

endmodule

// File: rtl/glb_ld_dma_addr_gen.sv
// Load-DMA address generator for one GLB tile. Accepts a descriptor on a
// start pulse, walks its nested loop space and emits one registered read
// request per active cycle, with optional active/inactive gap bursts.
//   clk, reset            : clock, synchronous active-high reset
//   ld_dma_header_i       : descriptor at the head of the header queue
//   ld_dma_start_pulse_i  : one-cycle start request
//   header_pop_o          : descriptor consumed (combinational, accept cycle)
//   rdrq_o                : registered {rd_en, rd_addr} read request
//   busy_o                : transfer in progress, accept until done pulse
//   ld_dma_done_pulse_o   : one cycle, the cycle after the last request
//   start_drop_cnt_o      : saturating count of ignored start pulses
module glb_ld_dma_addr_gen
  import glb_ld_dma_addr_gen_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  dma_ld_header_t                     ld_dma_header_i,
  input  logic                               ld_dma_start_pulse_i,
  output logic                               header_pop_o,
  output rdrq_packet_t                       rdrq_o,
  output logic                               busy_o,
  output logic                               ld_dma_done_pulse_o,
  output logic [LD_DMA_START_DROP_WIDTH-1:0] start_drop_cnt_o
);

  ld_dma_state_t                      state_q;
  logic                               fin_q;      // last word issued, done next
  logic [GLB_ADDR_WIDTH-1:0]          start_addr_q;
  logic [MAX_NUM_WORDS_WIDTH-1:0]     num_act_q, num_inact_q;
  logic [MAX_NUM_WORDS_WIDTH-1:0]     act_cnt_q, inact_cnt_q;
  rdrq_packet_t                       rdrq_q;
  logic                               busy_q, done_q;
  logic [LD_DMA_START_DROP_WIDTH-1:0] drop_cnt_q;

  logic                               accept_s, zero_words_s, issue_s;
  logic                               gaps_en_s, burst_end_s, last_s;
  logic [GLB_ADDR_WIDTH-1:0]          cur_start_s, offset_s, rd_addr_s;
  logic [MAX_NUM_WORDS_WIDTH-1:0]     cur_num_act_s, cur_num_inact_s, cur_act_cnt_s;
  ld_dma_state_t                      burst_state_s;
  logic                               burst_fin_s;
  logic [MAX_NUM_WORDS_WIDTH-1:0]     burst_act_cnt_s;

  // Accept decision and current-transfer parameters; word 0 issues in the
  // accept cycle itself so that it appears registered one cycle later.
  always_comb begin
    accept_s     = (state_q == IDLE) && ld_dma_start_pulse_i && ld_dma_header_i.valid;
    zero_words_s = (ld_dma_header_i.loop_ctrl[0].range == '0);
    if (accept_s) begin
      cur_start_s     = ld_dma_header_i.start_addr;
      cur_num_act_s   = ld_dma_header_i.num_active_words;
      cur_num_inact_s = ld_dma_header_i.num_inactive_words;
      cur_act_cnt_s   = '0;
      issue_s         = !zero_words_s;
    end else begin
      cur_start_s     = start_addr_q;
      cur_num_act_s   = num_act_q;
      cur_num_inact_s = num_inact_q;
      cur_act_cnt_s   = act_cnt_q;
      issue_s         = (state_q == ACTIVE) && !fin_q;
    end
    gaps_en_s   = (cur_num_act_s != '0) && (cur_num_inact_s != '0);
    burst_end_s = gaps_en_s &&
                  ((cur_act_cnt_s + MAX_NUM_WORDS_WIDTH'(1'b1)) == cur_num_act_s);
    rd_addr_s   = cur_start_s + (offset_s << ADDR_SHIFT);
  end

  // Where an issuing cycle leads: the last word wins over a burst end.
  always_comb begin
    if (last_s) begin
      burst_state_s   = ACTIVE;
      burst_fin_s     = 1'b1;
      burst_act_cnt_s = cur_act_cnt_s + MAX_NUM_WORDS_WIDTH'(1'b1);
    end else if (burst_end_s) begin
      burst_state_s   = INACTIVE;
      burst_fin_s     = 1'b0;
      burst_act_cnt_s = '0;
    end else begin
      burst_state_s   = ACTIVE;
      burst_fin_s     = 1'b0;
      burst_act_cnt_s = cur_act_cnt_s + MAX_NUM_WORDS_WIDTH'(1'b1);
    end
  end

  glb_loop_iter u_loop_iter (
    .clk         (clk),
    .reset       (reset),
    .load_i      (accept_s),
    .step_i      (issue_s),
    .loop_ctrl_i (ld_dma_header_i.loop_ctrl),
    .offset_o    (offset_s),
    .last_o      (last_s)
  );

  // Controller FSM with registered request, busy, done and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fin_q        <= 1'b0;
      start_addr_q <= '0;
      num_act_q    <= '0;
      num_inact_q  <= '0;
      act_cnt_q    <= '0;
      inact_cnt_q  <= '0;
      rdrq_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      rdrq_q.rd_en   <= issue_s;
      rdrq_q.rd_addr <= issue_s ? rd_addr_s : '0;
      done_q         <= 1'b0;
      if (ld_dma_start_pulse_i && !accept_s && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + LD_DMA_START_DROP_WIDTH'(1'b1);
      end
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            start_addr_q <= ld_dma_header_i.start_addr;
            num_act_q    <= ld_dma_header_i.num_active_words;
            num_inact_q  <= ld_dma_header_i.num_inactive_words;
            inact_cnt_q  <= '0;
            if (zero_words_s) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= burst_state_s;
              fin_q     <= burst_fin_s;
              act_cnt_q <= burst_act_cnt_s;
              busy_q    <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (fin_q) begin
            // Last request is on the bus this cycle; done follows it.
            state_q <= DONE;
            fin_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q     <= burst_state_s;
            fin_q       <= burst_fin_s;
            act_cnt_q   <= burst_act_cnt_s;
            inact_cnt_q <= '0;
          end
        end
        INACTIVE: begin
          if ((inact_cnt_q + MAX_NUM_WORDS_WIDTH'(1'b1)) == num_inact_q) begin
            state_q     <= ACTIVE;
            act_cnt_q   <= '0;
            inact_cnt_q <= '0;
          end else begin
            inact_cnt_q <= inact_cnt_q + MAX_NUM_WORDS_WIDTH'(1'b1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          fin_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign header_pop_o        = accept_s;
  assign rdrq_o              = rdrq_q;
  assign busy_o              = busy_q;
  assign ld_dma_done_pulse_o = done_q;
  assign start_drop_cnt_o    = drop_cnt_q;

endmodule

// File: doc/glb_ld_dma_addr_gen.md
Name: glb_ld_dma_addr_gen

Overview:
Load-DMA address generator for one GLB tile. It pops one dma_ld_header_t descriptor on a start pulse and walks the LOOP_LEVEL nested iteration space. Each cycle it emits an rdrq_packet_t read request toward the bank-select/SRAM read path, inserting the programmed active/inactive gaps. It raises a done pulse when the descriptor is exhausted.

Parameters:
GLB_ADDR_WIDTH, 22, byte address width of rd_addr and start_addr
BANK_DATA_WIDTH, 64, read word width in bits; address step per word = BANK_DATA_WIDTH/8 bytes
LOOP_LEVEL, 4, number of nested loop levels
MAX_NUM_WORDS_WIDTH, 16, width of range, num_active_words and num_inactive_words
MAX_STRIDE_WIDTH, 10, width of a per-level stride, in words

Ports:
clk  in  1  clock, single domain
reset  in  1  synchronous, active-high reset
ld_dma_header  in  $bits(dma_ld_header_t)  descriptor at head of header queue; .valid marks it usable
ld_dma_start_pulse  in  1  one-cycle start request
header_pop  out  1  one-cycle pulse: descriptor consumed, queue advances
rdrq  out  $bits(rdrq_packet_t)  {rd_en, rd_addr} read request, registered
busy  out  1  high from accept until done pulse
ld_dma_done_pulse  out  1  one-cycle pulse after last request
start_drop_cnt  out  8  saturating count of ignored start pulses

Behaviour:
- States: IDLE, ACTIVE, INACTIVE, DONE. Reset (synchronous) -> IDLE; rdrq=0, header_pop=0, busy=0, done=0, start_drop_cnt=0, all counters 0. Reset mid-transfer aborts immediately with no done pulse.
- Accept: in IDLE, start_pulse && header.valid -> latch header, header_pop=1 (same cycle, combinational), go ACTIVE, busy=1 next cycle.
- Start pulse in IDLE with header.valid=0, or in any other state: ignored; start_drop_cnt+1, saturating at 255.
- Latency: first rd_en=1 is registered at accept cycle+1, carrying rd_addr=start_addr.
- Loop order: level 0 is innermost.
  - addr = start_addr + ((Σ itr_i*stride_i) << log2(BANK_DATA_WIDTH/8)), modulo 2^GLB_ADDR_WIDTH.
  - No multipliers: hold per-level offset accumulators.
  - On level i increment: acc_i += stride_i, and every level below i resets to acc_i.
- Range 0 on a level is treated as 1 (level unused). Total words = Π max(range_i,1), except range_0==0: zero-word transfer, no rd_en, go straight to DONE.
- ACTIVE: one rd_en per cycle. After num_active_words consecutive requests with num_inactive_words!=0 -> INACTIVE. Stay there num_inactive_words cycles with rd_en=0, then back to ACTIVE.
- num_active_words==0 or num_inactive_words==0: continuous issue, no gaps.
- Last word issued in ACTIVE -> DONE. If the last word coincides with the end of an active burst, go to DONE, not INACTIVE.
- DONE lasts one cycle: ld_dma_done_pulse=1, busy=0, -> IDLE. A new start is accepted only from IDLE, i.e. one cycle after done.
- No backpressure: downstream must accept one request per cycle.

Decomposition:
- global_buffer_pkg gains:
  - ld_dma_state_t enum {IDLE, ACTIVE, INACTIVE, DONE}
  - localparam LD_DMA_START_DROP_WIDTH=8
- dma_ld_header_t, loop_ctrl_t and rdrq_packet_t are reused unchanged.
- Sub-module glb_loop_iter: the LOOP_LEVEL range counters, stride accumulators and the last-iteration flag. The parent holds the FSM and the active/inactive counter.

Test Plan:
- Start, header {start=0x100, range0=4, stride0=1, others 0, inactive=0} -> header_pop at T; rd_en T+1..T+4, addr 0x100,0x108,0x110,0x118; done pulse T+5.
- 2-level: range0=2 stride0=1, range1=3 stride1=4, start=0 -> addrs 0x00,0x08,0x20,0x28,0x40,0x48; then done.
- Gaps: range0=6, active=2, inactive=3 -> rd_en pattern 11 000 11 000 11, done the cycle after the last 1 (no trailing gap).
- Ignored starts: start with valid=0 -> no pop, cnt=1. Start while busy -> cnt=2, transfer unaffected. 300 ignored starts -> cnt stays 255.
- Edge cases: range0=0 -> pop, done pulse at T+1, rd_en never asserted. start=0x3FFFF8 (22-bit), range0=2 -> addrs 0x3FFFF8, 0x000000 (wrap).
- Reset asserted after the 2nd of 4 words -> rdrq, busy, done all 0 next cycle, no done pulse. A subsequent start is accepted normally.
